wb_regfile_stage: RTL and testbench
===================================

// Module: wb_regfile_stage
// PURPOSE
//  Write-back stage fed directly by the M/WB pipeline latch; commits results to the 4x8 register file.
//  Owns the stack pointer (R3), the registered output port and the sticky halt flag.
//  Provides two combinational read ports with write-through bypass to the decode stage.
//  Provides a retired-instruction counter for debug and performance monitoring.
// PARAMETERS
//  DATA_W    8       register / datapath width
//  SP_RESET  8'hFF   reset and re-init value of R3 (stack pointer)
//  CNT_W     16      width of retired-instruction counter
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  in_ra        in   2       register field A from M/WB latch
//  in_rb        in   2       register field B from M/WB latch
//  in_RW        in   1       register write enable
//  in_SP        in   2       SP op: 00 hold, 01 inc, 10 dec, 11 re-init to SP_RESET
//  in_SW1       in   1       write address select: 0 = ra, 1 = rb
//  in_SW2       in   1       write data select: 0 = in_DataOut, 1 = in_port
//  in_out_ld    in   1       load output port from R[rb]
//  in_DataOut   in   DATA_W  memory/ALU result from M/WB latch
//  in_Hlt       in   1       halt instruction reached write-back
//  in_port      in   DATA_W  external input port, sampled at the clock edge
//  rd_addr_a    in   2       decode read address A
//  rd_addr_b    in   2       decode read address B
//  rd_data_a    out  DATA_W  R[rd_addr_a], bypassed
//  rd_data_b    out  DATA_W  R[rd_addr_b], bypassed
//  sp_value     out  DATA_W  current R3
//  out_port     out  DATA_W  registered output port
//  out_valid    out  1       one-cycle pulse when out_port updates
//  halted       out  1       sticky halt flag
//  retired_cnt  out  CNT_W   count of non-bubble instructions committed
// BEHAVIOUR
//  - Reset (asynchronous, active-high):
//    - R0..R2 = 0; R3 = SP_RESET.
//    - out_port = 0, out_valid = 0, halted = 0, retired_cnt = 0.
//  - Effective write enable: we = in_RW & ~halted.
//    - Write address: waddr = in_SW1 ? in_rb : in_ra.
//    - Write data: wdata = in_SW2 ? in_port : in_DataOut.
//    - Commit is on the rising edge; latency is 1 cycle.
//  - SP update (when ~halted), modulo 2^DATA_W:
//    - inc: 8'hFF -> 8'h00 wraps.
//    - dec: 8'h00 -> 8'hFF wraps.
//  - Conflict rule: if we and waddr == 3 in the same cycle as an SP op, the RW write wins and the SP op is dropped.
//  - Output port:
//    - When in_out_ld & ~halted: out_port <= R[in_rb], using pre-edge (old) register contents.
//    - out_valid <= 1 for exactly that cycle, else 0.
//  - Halt:
//    - in_Hlt & ~halted -> halted <= 1 at the edge.
//    - Writes, SP ops and out_ld present in the same cycle as in_Hlt still commit.
//    - After that edge all commits are blocked and the inputs are ignored.
//    - Only reset clears halted.
//  - Read ports are combinational.
//    - Bypass: if we & (rd_addr == waddr), rd_data = wdata.
//    - Bypass: else if rd_addr == 3 and an SP op is pending, rd_data = next SP value.
//  - Retire: retired_cnt += 1 when ~halted and any of in_RW, in_SP != 0, in_out_ld, in_Hlt is set.
//    - An all-zero (flushed) bundle is a bubble and is not counted.
//    - Counter saturates at all-ones.
//  - Reset asserted mid-operation aborts any pending commit; state is restored to reset values immediately.
// STRUCTURE
//  - Shared package holds:
//    - SP op codes: SP_HOLD, SP_INC, SP_DEC, SP_INIT.
//    - SP_RESET default.
//    - REG_SP = 2'd3.
//  - One sub-module: regfile_4x8 (storage, write port, two bypassed read ports, R3 reset value).
//  - SP arithmetic, out port, halt and counter stay in the top level.
// TESTING
//  1. Reset -> rd R3 = 8'hFF, R0 = 0, halted = 0, retired_cnt = 0, out_valid = 0.
//  2. RW=1, SW1=0, ra=1, SW2=0, DataOut=8'h5A
//     -> same-cycle rd_addr_a=1 reads 8'h5A (bypass); after the edge R1 = 8'h5A; retired_cnt = 1.
//  3. SP=10 from R3=8'h00 -> R3 = 8'hFF (wrap).
//     Then RW=1 to waddr=3 with DataOut=8'h40 and SP=01 in the same cycle -> R3 = 8'h40.
//  4. R2=8'h33, out_ld=1, rb=2 -> next cycle out_port = 8'h33, out_valid high for exactly 1 cycle.
//     Also: SW2=1, in_port=8'hC7, RW=1, ra=0 -> R0 = 8'hC7.
//  5. in_Hlt=1 with RW=1 to R1 (8'h11) in the same cycle -> R1 = 8'h11 and halted = 1.
//     Subsequent RW/SP/out_ld bundles cause no changes; retired_cnt stays frozen.
//  6. All-zero bubble -> no state change and retired_cnt unchanged.
//     Reset pulsed mid-sequence -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/wb_regfile_stage_pkg.sv
// Shared definitions for the write-back stage: SP op codes, register indices and defaults.
package wb_regfile_stage_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 8;
  localparam int unsigned CNT_W_DEFAULT    = 16;
  localparam int unsigned NUM_REGS         = 4;
  localparam logic [7:0]  SP_RESET_DEFAULT = 8'hFF;
  localparam logic [1:0]  REG_SP           = 2'd3;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_INC  = 2'b01,
    SP_DEC  = 2'b10,
    SP_INIT = 2'b11
  } sp_op_e;

endpackage

// File: rtl/regfile_4x8.sv
// Four-entry register file: one write port, an SP update port on R3,
// two bypassed decode read ports and one raw (pre-edge) read port.
module regfile_4x8
  import wb_regfile_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sp_we,
  input  logic [DATA_W-1:0] sp_wdata,
  input  logic [1:0]        rd_addr_a,
  input  logic [1:0]        rd_addr_b,
  input  logic [1:0]        raw_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] raw_data,
  output logic [DATA_W-1:0] sp_value
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Register write has priority over the SP port on R3; the top already masks sp_we on conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= (i == 3) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && (waddr == 2'(i))) begin
          mem[i] <= wdata;
        end else if ((i == 3) && sp_we) begin
          mem[i] <= sp_wdata;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] bypass_read(input logic [1:0] addr);
    if (we && (addr == waddr)) begin
      return wdata;
    end else if ((addr == REG_SP) && sp_we) begin
      return sp_wdata;
    end
    return mem[addr];
  endfunction

  assign rd_data_a = bypass_read(rd_addr_a);
  assign rd_data_b = bypass_read(rd_addr_b);
  assign raw_data  = mem[raw_addr];
  assign sp_value  = mem[REG_SP];

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: commits M/WB results, owns the stack pointer, output port,
// sticky halt flag and the retired-instruction counter.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT),
  parameter int unsigned       CNT_W    = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        in_ra,
  input  logic [1:0]        in_rb,
  input  logic              in_RW,
  input  logic [1:0]        in_SP,
  input  logic              in_SW1,
  input  logic              in_SW2,
  input  logic              in_out_ld,
  input  logic [DATA_W-1:0] in_DataOut,
  input  logic              in_Hlt,
  input  logic [DATA_W-1:0] in_port,
  input  logic [1:0]        rd_addr_a,
  input  logic [1:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] sp_value,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  sp_op_e            sp_op;
  logic              we;
  logic [1:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic              sp_we;
  logic [DATA_W-1:0] sp_next;
  logic [DATA_W-1:0] rb_old;
  logic              retire;

  assign sp_op = sp_op_e'(in_SP);
  assign we    = in_RW & ~halted;
  assign waddr = in_SW1 ? in_rb : in_ra;
  assign wdata = in_SW2 ? in_port : in_DataOut;
  // A register write to R3 in the same bundle overrides the SP op.
  assign sp_we = ~halted & (sp_op != SP_HOLD) & ~(we & (waddr == REG_SP));

  always_comb begin
    sp_next = sp_value;
    case (sp_op)
      SP_INC:  sp_next = sp_value + DATA_W'(1);
      SP_DEC:  sp_next = sp_value - DATA_W'(1);
      SP_INIT: sp_next = SP_RESET;
      default: sp_next = sp_value;
    endcase
  end

  assign retire = ~halted & (in_RW | (in_SP != 2'b00) | in_out_ld | in_Hlt);

  regfile_4x8 #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .sp_we     (sp_we),
    .sp_wdata  (sp_next),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .raw_addr  (in_rb),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .raw_data  (rb_old),
    .sp_value  (sp_value)
  );

  // Output port, halt flag and saturating retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port    <= '0;
      out_valid   <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      out_valid <= in_out_ld & ~halted;
      if (in_out_ld && !halted) begin
        out_port <= rb_old;
      end
      if (in_Hlt) begin
        halted <= 1'b1;
      end
      if (retire && (retired_cnt != '1)) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed steps plus random bundles against a behavioural model.
module tb_wb_regfile_stage;

  logic       clk;
  logic       reset;
  logic [1:0] in_ra, in_rb, in_SP, rd_addr_a, rd_addr_b;
  logic       in_RW, in_SW1, in_SW2, in_out_ld, in_Hlt;
  logic [7:0] in_DataOut, in_port;
  logic [7:0] rd_data_a, rd_data_b, sp_value, out_port;
  logic       out_valid, halted;
  logic [15:0] retired_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0]  m_r [4];
  logic [7:0]  m_out;
  logic        m_valid, m_halt;
  logic [15:0] m_cnt;
  logic [7:0]  n_r [4];
  logic [7:0]  n_out;
  logic        n_valid, n_halt;
  logic [15:0] n_cnt;

  wb_regfile_stage dut (
    .clk(clk), .reset(reset), .in_ra(in_ra), .in_rb(in_rb), .in_RW(in_RW),
    .in_SP(in_SP), .in_SW1(in_SW1), .in_SW2(in_SW2), .in_out_ld(in_out_ld),
    .in_DataOut(in_DataOut), .in_Hlt(in_Hlt), .in_port(in_port),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .sp_value(sp_value), .out_port(out_port),
    .out_valid(out_valid), .halted(halted), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    in_ra = 0; in_rb = 0; in_RW = 0; in_SP = 0; in_SW1 = 0; in_SW2 = 0;
    in_out_ld = 0; in_DataOut = 0; in_Hlt = 0; in_port = 0;
  endtask

  task automatic model_reset();
    m_r[0] = 0; m_r[1] = 0; m_r[2] = 0; m_r[3] = 8'hFF;
    m_out = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
  endtask

  // Next architectural state from the current bundle.
  task automatic model_next();
    logic [1:0] wa;
    logic [7:0] wd;
    for (int i = 0; i < 4; i++) n_r[i] = m_r[i];
    n_out = m_out; n_valid = 0; n_halt = m_halt; n_cnt = m_cnt;
    wa = in_SW1 ? in_rb : in_ra;
    wd = in_SW2 ? in_port : in_DataOut;
    if (!m_halt) begin
      if (in_SP != 0 && !(in_RW && wa == 2'd3)) begin
        if (in_SP == 2'b01) n_r[3] = 8'((int'(m_r[3]) + 1) % 256);
        else if (in_SP == 2'b10) n_r[3] = 8'((int'(m_r[3]) + 255) % 256);
        else n_r[3] = 8'hFF;
      end
      if (in_RW) n_r[wa] = wd;
      if (in_out_ld) begin n_out = m_r[in_rb]; n_valid = 1; end
      if (in_Hlt) n_halt = 1;
      if ((in_RW || in_SP != 0 || in_out_ld || in_Hlt) && m_cnt != 16'hFFFF) n_cnt = m_cnt + 1;
    end
  endtask

  // Apply the bundle currently on the inputs for one clock and check everything.
  task automatic step();
    model_next();
    #2;
    chk("rd_a_bypass", 32'(rd_data_a), 32'(n_r[rd_addr_a]));
    chk("rd_b_bypass", 32'(rd_data_b), 32'(n_r[rd_addr_b]));
    chk("sp_pre", 32'(sp_value), 32'(m_r[3]));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) m_r[i] = n_r[i];
    m_out = n_out; m_valid = n_valid; m_halt = n_halt; m_cnt = n_cnt;
    chk("sp_post", 32'(sp_value), 32'(m_r[3]));
    chk("out_port", 32'(out_port), 32'(m_out));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
  endtask

  // Reset pulse between edges; a pending write on the inputs must be discarded.
  task automatic pulse_reset();
    in_RW = 1; in_ra = 2'd1; in_DataOut = 8'hEE; in_SP = 2'b01;
    #1 reset = 1;
    #1;
    model_reset();
    bubble();
    rd_addr_a = 2'd3; rd_addr_b = 2'd0;
    #1;
    chk("rst_sp", 32'(sp_value), 32'hFF);
    chk("rst_rd_a_r3", 32'(rd_data_a), 32'hFF);
    chk("rst_rd_b_r0", 32'(rd_data_b), 32'h0);
    chk("rst_out_port", 32'(out_port), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cnt", 32'(retired_cnt), 32'h0);
    reset = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bubble(); in_RW = 1; in_ra = a; in_DataOut = d;
  endtask

  initial begin
    logic [15:0] frozen;
    int since_halt;
    reset = 1;
    bubble();
    rd_addr_a = 0; rd_addr_b = 0;
    model_reset();
    @(posedge clk); #1;
    pulse_reset();

    // Write R1 through DataOut with same-cycle bypass
    wr(2'd1, 8'h5A); rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    step();
    chk("r1_cnt_one", 32'(retired_cnt), 32'd1);
    bubble(); rd_addr_a = 2'd1;
    #2 chk("r1_is_5a", 32'(rd_data_a), 32'h5A);
    step();

    // SP decrement wraps 00 -> FF, then RW to R3 beats SP inc
    wr(2'd3, 8'h00); step();
    bubble(); in_SP = 2'b10; rd_addr_a = 2'd3; step();
    chk("sp_wrap_dec", 32'(sp_value), 32'hFF);
    bubble(); in_SP = 2'b01; step();
    chk("sp_wrap_inc", 32'(sp_value), 32'h00);
    wr(2'd3, 8'h40); in_SP = 2'b01; step();
    chk("rw_beats_sp", 32'(sp_value), 32'h40);

    // Output port from R2 and in_port write to R0
    wr(2'd2, 8'h33); step();
    bubble(); in_out_ld = 1; in_rb = 2'd2; step();
    chk("outport_33", 32'(out_port), 32'h33);
    chk("outvalid_hi", 32'(out_valid), 32'h1);
    bubble(); in_SW2 = 1; in_port = 8'hC7; in_RW = 1; in_ra = 2'd0; rd_addr_b = 2'd0; step();
    chk("outvalid_lo", 32'(out_valid), 32'h0);
    bubble(); rd_addr_b = 2'd0;
    #2 chk("r0_is_c7", 32'(rd_data_b), 32'hC7);
    step();

    // Halt with a same-cycle write, then frozen
    wr(2'd1, 8'h11); in_Hlt = 1; rd_addr_a = 2'd1; step();
    chk("halt_set", 32'(halted), 32'h1);
    frozen = retired_cnt;
    for (int i = 0; i < 6; i++) begin
      in_RW = 1; in_ra = 2'(i); in_DataOut = 8'($urandom); in_SP = 2'($urandom);
      in_out_ld = 1; in_rb = 2'(i); rd_addr_a = 2'(i);
      step();
    end
    chk("cnt_frozen", 32'(retired_cnt), 32'(frozen));
    bubble(); rd_addr_a = 2'd1;
    #2 chk("r1_is_11", 32'(rd_data_a), 32'h11);
    step();
    pulse_reset();

    // Bubble leaves state and counter untouched
    wr(2'd2, 8'h9C); step();
    frozen = retired_cnt;
    bubble(); rd_addr_a = 2'd2; step();
    chk("bubble_cnt", 32'(retired_cnt), 32'(frozen));
    chk("bubble_r2", 32'(rd_data_a), 32'h9C);

    // Random bundles with occasional halts and mid-cycle resets
    since_halt = 0;
    for (int n = 0; n < 400; n++) begin
      in_ra = 2'($urandom); in_rb = 2'($urandom);
      in_RW = ($urandom_range(1, 0) == 1);
      in_SP = 2'($urandom);
      in_SW1 = ($urandom_range(1, 0) == 1);
      in_SW2 = ($urandom_range(3, 0) == 0);
      in_out_ld = ($urandom_range(3, 0) == 0);
      in_DataOut = 8'($urandom); in_port = 8'($urandom);
      in_Hlt = ($urandom_range(49, 0) == 0);
      if ($urandom_range(3, 0) == 0) begin
        in_RW = 0; in_SP = 0; in_out_ld = 0; in_Hlt = 0;
      end
      rd_addr_a = 2'($urandom); rd_addr_b = 2'($urandom);
      step();
      if (m_halt) since_halt++;
      if (since_halt > 4 || $urandom_range(59, 0) == 0) begin
        pulse_reset();
        since_halt = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
